rx_sync_ctrl: RTL



---
 rtl/rx_phy_pkg.sv | 16 +
 rtl/sat_counter.sv | 21 ++
 rtl/rx_sync_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/rx_phy_pkg.sv
// Shared definitions for the PHY receive path.
// State encoding, symbol width and the default comma symbol.
package rx_phy_pkg;

    localparam int SYM_W = 8;

    localparam logic [SYM_W-1:0] COM_SYM_DEF = 8'hBC;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_HUNT     = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_RECOVER  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones.
// Cleared only by the synchronous active-low reset.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count up on inc, hold once the maximum value is reached.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/rx_sync_ctrl.sv
// Receive link-sync controller: hunt for COM run, forward data, drop on errors.
// Optional statistics outputs are enabled with RX_SYNC_CTRL_STATS_EN.
module rx_sync_ctrl
    import rx_phy_pkg::*;
#(
    parameter logic [SYM_W-1:0] COM_SYM    = COM_SYM_DEF,
    parameter int               LOCK_COUNT = 4,
    parameter int               LOSS_COUNT = 3
) (
    input  logic             clk_4f,
    input  logic             reset,
    input  logic             enable,
    input  logic [SYM_W-1:0] byte_in,
    input  logic             sym_err,
    output logic [SYM_W-1:0] data_out,
    output logic             valid_out,
    output logic             locked,
    output logic             lock_lost,
    output logic [1:0]       state
`ifdef RX_SYNC_CTRL_STATS_EN
    ,
    output logic [7:0]       err_total,
    output logic [7:0]       relock_count
`endif
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

    rx_state_e        state_q, state_d;
    logic [3:0]       com_q, com_d;
    logic [3:0]       err_q, err_d;
    logic [SYM_W-1:0] data_d;
    logic             valid_d;
    logic             lost_d;
    logic             clean_com;
    logic [3:0]       com_inc;
    logic [3:0]       err_inc;

    assign clean_com = (byte_in == COM_SYM) && !sym_err;
    assign com_inc   = com_q + 4'd1;
    assign err_inc   = err_q + 4'd1;

    // Next-state and next-output decisions from current state and inputs.
    always_comb begin
        state_d = state_q;
        com_d   = com_q;
        err_d   = err_q;
        data_d  = data_out;
        valid_d = 1'b0;
        lost_d  = 1'b0;
        if (!enable) begin
            state_d = ST_DISABLED;
            com_d   = 4'd0;
            err_d   = 4'd0;
        end else begin
            unique case (state_q)
                ST_DISABLED: begin
                    state_d = ST_HUNT;
                    com_d   = 4'd0;
                end
                ST_HUNT: begin
                    if (clean_com) begin
                        if (com_inc == LOCK_N) begin
                            state_d = ST_LOCKED;
                            com_d   = 4'd0;
                            err_d   = 4'd0;
                        end else begin
                            com_d = com_inc;
                        end
                    end else begin
                        com_d = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    data_d = byte_in;
                    if (sym_err) begin
                        if (err_inc == LOSS_N) begin
                            state_d = ST_RECOVER;
                            lost_d  = 1'b1;
                            err_d   = 4'd0;
                        end else begin
                            err_d = err_inc;
                        end
                    end else begin
                        err_d   = 4'd0;
                        valid_d = (byte_in != COM_SYM);
                    end
                end
                ST_RECOVER: begin
                    state_d = ST_HUNT;
                    com_d   = 4'd0;
                end
                default: begin
                    state_d = ST_DISABLED;
                end
            endcase
        end
    end

    // Register state, counters and all outputs.
    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            state_q   <= ST_DISABLED;
            com_q     <= 4'd0;
            err_q     <= 4'd0;
            data_out  <= '0;
            valid_out <= 1'b0;
            locked    <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state_q   <= state_d;
            com_q     <= com_d;
            err_q     <= err_d;
            data_out  <= data_d;
            valid_out <= valid_d;
            locked    <= (state_d == ST_LOCKED);
            lock_lost <= lost_d;
        end
    end

    assign state = state_q;

`ifdef RX_SYNC_CTRL_STATS_EN
    logic err_hit;
    logic relock_hit;

    assign err_hit    = enable && (state_q == ST_LOCKED) && sym_err;
    assign relock_hit = enable && (state_q == ST_HUNT) && (state_d == ST_LOCKED);

    sat_counter #(.WIDTH(8)) u_err_total (
        .clk   (clk_4f),
        .reset (reset),
        .inc   (err_hit),
        .count (err_total)
    );

    sat_counter #(.WIDTH(8)) u_relock_count (
        .clk   (clk_4f),
        .reset (reset),
        .inc   (relock_hit),
        .count (relock_count)
    );
`endif

endmodule
